// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first, mid-bit sampling.
// Owns its bit-period counter; hands bytes over through a valid/ack level
// handshake and reports framing errors and overruns.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Synchronizer and current-state registers
    logic                 r_rx_meta;
    logic                 r_rx_s;
    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIT_W-1:0]     r_bitn;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_data_valid;
    logic                 r_frame_error;
    logic                 r_overrun;
    logic                 r_busy;

    // Next-state values from the combinational block
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [BIT_W-1:0]     w_bitn_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] w_data_nxt;
    logic                 w_data_valid_nxt;
    logic                 w_frame_error_nxt;
    logic                 w_overrun_nxt;
    logic                 w_acked;

    assign data        = r_data;
    assign data_valid  = r_data_valid;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;
    assign busy        = r_busy;

    // Two-flop synchronizer for the asynchronous line; resets to idle-high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // State, counters, shift register and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bitn        <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_bitn        <= w_bitn_nxt;
            r_shift       <= w_shift_nxt;
            r_data        <= w_data_nxt;
            r_data_valid  <= w_data_valid_nxt;
            r_frame_error <= w_frame_error_nxt;
            r_overrun     <= w_overrun_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
        end
    end

    // Next-state, bit timing, sampling and handshake logic
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_bitn_nxt        = r_bitn;
        w_shift_nxt       = r_shift;
        w_data_nxt        = r_data;
        w_data_valid_nxt  = r_data_valid;
        w_frame_error_nxt = 1'b0;
        w_overrun_nxt     = r_overrun;
        w_acked           = rd_ack && r_data_valid;

        // Consumer ack clears the level flags; a completing frame below overrides
        if (w_acked) begin
            w_data_valid_nxt = 1'b0;
            w_overrun_nxt    = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end

            S_START: begin
                // Re-check the line at mid start bit to reject glitches
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nxt = '0;
                    if (!r_rx_s) begin
                        w_state_nxt = S_DATA;
                        w_bitn_nxt  = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_DATA: begin
                // Right-shift in LSB first: after the last bit, bit k sits at index k
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
                    if (r_bitn == BIT_LAST) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bitn_nxt = r_bitn + BIT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        // Good frame: new byte always wins, even against an ack
                        w_data_nxt       = r_shift;
                        w_data_valid_nxt = 1'b1;
                        if (r_data_valid && !rd_ack) begin
                            w_overrun_nxt = 1'b1;
                        end
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_error_nxt = 1'b1;
                        w_state_nxt       = S_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_BREAK: begin
                // A held-low line must return high before a new start is armed
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_bitn_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against an event-level model of the receiver.
module tb_uart_rx;

    localparam int unsigned CPB = 8;
    localparam int unsigned DB  = 8;
    // Start edge driven before clock s  ->  stop sampled at clock s + LAT
    localparam int LAT = 2 + CPB / 2 + (DB + 1) * CPB;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx      = 1'b1;
    logic          rd_ack  = 1'b0;
    logic [DB-1:0] data;
    logic          data_valid;
    logic          frame_error;
    logic          overrun;
    logic          busy;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .rd_ack     (rd_ack),
        .data       (data),
        .data_valid (data_valid),
        .frame_error(frame_error),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int   cyc      = 0;
    logic ack_seen = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        ack_seen <= rd_ack;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    endtask

    // Model: expected outputs derived from scheduled frame events
    int         comp_cyc[$];
    logic [7:0] comp_data[$];
    logic       comp_good[$];
    int         win_from[$];
    int         win_to[$];

    logic [7:0] m_data  = '0;
    logic       m_valid = 1'b0;
    logic       m_fe    = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_busy  = 1'b0;

    initial forever begin
        logic old_valid;
        logic acked;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            m_data = '0; m_valid = 1'b0; m_fe = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
        end else begin
            old_valid = m_valid;
            acked     = ack_seen && old_valid;
            if (acked) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            m_fe = 1'b0;
            if (comp_cyc.size() > 0 && comp_cyc[0] == cyc) begin
                if (comp_good[0]) begin
                    if (old_valid && !acked) m_ovr = 1'b1;
                    m_data  = comp_data[0];
                    m_valid = 1'b1;
                end else begin
                    m_fe = 1'b1;
                end
                void'(comp_cyc.pop_front());
                void'(comp_data.pop_front());
                void'(comp_good.pop_front());
            end
            m_busy = 1'b0;
            foreach (win_from[i])
                if (cyc >= win_from[i] && cyc < win_to[i]) m_busy = 1'b1;
        end
        chk("data",        32'(data),        32'(m_data));
        chk("data_valid",  32'(data_valid),  32'(m_valid));
        chk("frame_error", 32'(frame_error), 32'(m_fe));
        chk("overrun",     32'(overrun),     32'(m_ovr));
        chk("busy",        32'(busy),        32'(m_busy));
    end

    // Observed-event bookkeeping for literal checks
    int   last_rise = -1;
    int   fe_count  = 0;
    logic dv_prev   = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (data_valid && !dv_prev) last_rise = cyc;
        dv_prev = data_valid;
        if (frame_error) fe_count++;
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    // Called on a negedge; schedules the model events then drives the frame
    task automatic send_frame(input logic [7:0] d, input logic stop);
        int s;
        s = cyc + 1;
        comp_cyc.push_back(s + LAT);
        comp_data.push_back(d);
        comp_good.push_back(stop);
        win_from.push_back(s + 2);
        win_to.push_back(stop ? s + LAT : 32'h7fff_ffff);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
    endtask

    initial begin
        int s;
        int r;

        // Reset sanity with a toggling line
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rx = ~rx;
        end
        @(negedge clk);
        rx = 1'b1;
        chk("rst_busy",  32'(busy),       32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        reset_n = 1'b1;
        tick(10);
        chk("post_rst_busy", 32'(busy), 32'h0);

        // Single byte with latency pin
        s = cyc + 1;
        send_frame(8'hA5, 1'b1);
        tick(2);
        chk("a5_data",    32'(data),       32'hA5);
        chk("a5_valid",   32'(data_valid), 32'h1);
        chk("a5_latency", 32'(last_rise - s), 32'd78);
        chk("a5_fe",      32'(fe_count),   32'h0);
        ack_pulse();
        tick(2);
        chk("a5_acked", 32'(data_valid), 32'h0);

        // Back-to-back frames, no ack: overrun
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        tick(4);
        chk("b2b_data",    32'(data),       32'hC3);
        chk("b2b_valid",   32'(data_valid), 32'h1);
        chk("b2b_overrun", 32'(overrun),    32'h1);
        ack_pulse();
        tick(2);
        chk("b2b_ack_valid",   32'(data_valid), 32'h0);
        chk("b2b_ack_overrun", 32'(overrun),    32'h0);

        // Start glitch of two clocks
        s = cyc + 1;
        win_from.push_back(s + 2);
        win_to.push_back(s + 2 + CPB / 2);
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(20);
        chk("glitch_valid", 32'(data_valid), 32'h0);
        chk("glitch_fe",    32'(fe_count),   32'h0);
        chk("glitch_busy",  32'(busy),       32'h0);

        // Framing error followed by a long break
        send_frame(8'h55, 1'b0);
        tick(40);
        chk("brk_busy", 32'(busy), 32'h1);
        r = cyc + 1;
        rx = 1'b1;
        win_to[win_to.size() - 1] = r + 2;
        tick(20);
        chk("brk_fe_pulses", 32'(fe_count),   32'd1);
        chk("brk_valid",     32'(data_valid), 32'h0);
        chk("brk_idle",      32'(busy),       32'h0);
        send_frame(8'h0F, 1'b1);
        tick(4);
        chk("after_brk_data", 32'(data), 32'h0F);

        // Ack landing on the stop-sample clock of a new good frame
        fork
            send_frame(8'h81, 1'b1);
            begin
                tick(LAT);
                ack_pulse();
            end
        join
        tick(4);
        chk("coll_data",    32'(data),       32'h81);
        chk("coll_valid",   32'(data_valid), 32'h1);
        chk("coll_overrun", 32'(overrun),    32'h0);
        ack_pulse();
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
